// File: rtl/ir_fetch_decode.sv
// ----------------------------------------------------------------------------
// ir_fetch_decode
//   Instruction fetch / IR stage of the LC-3 datapath. On a fetch request it
//   issues a memory read at the given PC. It latches the returned word into
//   the instruction register. It then slices the IR into the raw LC-3 fields
//   and holds them stable for the control unit and the downstream
//   sign_extender instances. A watchdog abandons a fetch that memory never
//   acknowledges.
//
// Ports
//   clk, rst_n             clock (rising edge), synchronous active-low reset
//   fetch_start, fetch_pc  one-cycle fetch request and its address (IDLE only)
//   mem_req, mem_addr      memory read request/address, held until mem_ack
//   mem_ack, mem_rdata     memory response and instruction word
//   dec_valid, dec_ready   decoded-field handshake towards the control unit
//   ir                     instruction register
//   opcode .. trapvect8    raw IR bit fields (no extension, no arithmetic)
//   busy                   high whenever the FSM is not in IDLE
//   fetch_err              one-cycle pulse when a fetch aborts on timeout
//   fsm_state              current FSM state (debug visibility)
//
// Handshake: the field outputs carry a transfer on every rising edge that has
// dec_valid=1 and dec_ready=1. Once dec_valid is raised, it stays high until
// that transfer. The fields do not change while dec_valid=1. dec_valid never
// depends on dec_ready in the same cycle.
// ----------------------------------------------------------------------------
module ir_fetch_decode #(
   parameter int ADDR_WIDTH  = 16,
   parameter int DATA_WIDTH  = 16,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  fetch_start,
   input  logic [ADDR_WIDTH-1:0] fetch_pc,
   output logic                  mem_req,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic                  mem_ack,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  dec_valid,
   input  logic                  dec_ready,
   output logic [DATA_WIDTH-1:0] ir,
   output logic [3:0]            opcode,
   output logic [2:0]            dr,
   output logic [2:0]            sr1,
   output logic [2:0]            sr2,
   output logic                  imm_mode,
   output logic [4:0]            imm5,
   output logic [5:0]            offset6,
   output logic [8:0]            pcoffset9,
   output logic [10:0]           pcoffset11,
   output logic [7:0]            trapvect8,
   output logic                  busy,
   output logic                  fetch_err,
   output logic [1:0]            fsm_state
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FETCH  = 2'd1,
      DECODE = 2'd2,
      HOLD   = 2'd3
   } state_t;

   // The counter value on the last FETCH cycle before the fetch gives up.
   // With the counter starting at 0, the abort happens after MEM_TIMEOUT FETCH
   // cycles.
   localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

   state_t     state;
   logic [7:0] tmo_cnt;

   assign busy      = (state != IDLE);
   assign fsm_state = state;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         tmo_cnt    <= 8'd0;
         mem_req    <= 1'b0;
         mem_addr   <= '0;
         ir         <= '0;
         dec_valid  <= 1'b0;
         fetch_err  <= 1'b0;
         opcode     <= 4'd0;
         dr         <= 3'd0;
         sr1        <= 3'd0;
         sr2        <= 3'd0;
         imm_mode   <= 1'b0;
         imm5       <= 5'd0;
         offset6    <= 6'd0;
         pcoffset9  <= 9'd0;
         pcoffset11 <= 11'd0;
         trapvect8  <= 8'd0;
      end else begin
         // fetch_err is a pulse. Only the abort branch below re-asserts it.
         fetch_err <= 1'b0;
         case (state)
            IDLE: begin
               // mem_ack is ignored here. fetch_start is only looked at in IDLE.
               if (fetch_start) begin
                  mem_addr <= fetch_pc;
                  mem_req  <= 1'b1;
                  tmo_cnt  <= 8'd0;
                  state    <= FETCH;
               end
            end
            FETCH: begin
               // An ack on the timeout cycle still wins over the abort.
               if (mem_ack) begin
                  ir      <= mem_rdata;
                  mem_req <= 1'b0;
                  state   <= DECODE;
               end else if (tmo_cnt == TMO_LAST) begin
                  mem_req   <= 1'b0;
                  fetch_err <= 1'b1;
                  state     <= IDLE;
               end else begin
                  tmo_cnt <= tmo_cnt + 8'd1;
               end
            end
            DECODE: begin
               // The fields are plain slices of ir. They are registered here
               // so that they are stable for the whole time dec_valid is high.
               opcode     <= ir[15:12];
               dr         <= ir[11:9];
               sr1        <= ir[8:6];
               sr2        <= ir[2:0];
               imm_mode   <= ir[5];
               imm5       <= ir[4:0];
               offset6    <= ir[5:0];
               pcoffset9  <= ir[8:0];
               pcoffset11 <= ir[10:0];
               trapvect8  <= ir[7:0];
               dec_valid  <= 1'b1;
               state      <= HOLD;
            end
            HOLD: begin
               if (dec_ready) begin
                  dec_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
